// File: rtl/user_flash_pkg.sv
// user_flash_pkg: GW1NR-9 user flash geometry, writer FSM encoding and ns-to-cycle helpers
package user_flash_pkg;
  localparam int FLASH_ROWS = 304;
  localparam int FLASH_COLS = 64;
  localparam int ROW_W = 9;
  localparam int COL_W = $clog2(FLASH_COLS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(FLASH_ROWS);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_NVSTR = 3'd2;
  localparam logic [2:0] S_PROG  = 3'd3;
  localparam logic [2:0] S_ADH   = 3'd4;
  localparam logic [2:0] S_NVH   = 3'd5;
  localparam logic [2:0] S_RCV   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;
  function automatic longint unsigned ns_to_cycles(input longint unsigned ns, input longint unsigned freq);
    longint unsigned c;
    c = (ns * freq + 64'd999_999_999) / 64'd1_000_000_000;
    return (c == 64'd0) ? 64'd1 : c;
  endfunction
  function automatic longint unsigned lmax(input longint unsigned a, input longint unsigned b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/flash_delay_timer.sv
// flash_delay_timer: loadable down-counter, expired while the count sits at zero
module flash_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;
  // load on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expired = (cnt == '0);
endmodule

// File: rtl/user_flash_writer.sv
// user_flash_writer: sequences row erase and word program strobes for the GW1NR-9 user flash
module user_flash_writer
  import user_flash_pkg::*;
#(
  parameter longint unsigned CLK_FREQ   = 27_000_000,
  parameter longint unsigned T_NVS_NS   = 5_000,
  parameter longint unsigned T_PGS_NS   = 10_000,
  parameter longint unsigned T_PROG_NS  = 16_000,
  parameter longint unsigned T_ERASE_NS = 100_000_000,
  parameter longint unsigned T_NVH_NS   = 5_000,
  parameter longint unsigned T_RCV_NS   = 10_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_erase,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_i,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              inv_valid,
  output logic [ADDR_W-1:0] inv_addr,
  output logic              flash_xe,
  output logic              flash_ye,
  output logic              flash_prog,
  output logic              flash_erase,
  output logic              flash_nvstr,
  output logic [ROW_W-1:0]  flash_xadr,
  output logic [COL_W-1:0]  flash_yadr,
  output logic [31:0]       flash_din
);
  localparam longint unsigned N_NVS   = ns_to_cycles(T_NVS_NS, CLK_FREQ);
  localparam longint unsigned N_PGS   = ns_to_cycles(T_PGS_NS, CLK_FREQ);
  localparam longint unsigned N_PROG  = ns_to_cycles(T_PROG_NS, CLK_FREQ);
  localparam longint unsigned N_ERASE = ns_to_cycles(T_ERASE_NS, CLK_FREQ);
  localparam longint unsigned N_NVH   = ns_to_cycles(T_NVH_NS, CLK_FREQ);
  localparam longint unsigned N_RCV   = ns_to_cycles(T_RCV_NS, CLK_FREQ);
  localparam longint unsigned N_MAX   = lmax(lmax(lmax(N_NVS, N_PGS), lmax(N_PROG, N_ERASE)), lmax(N_NVH, N_RCV));
  localparam int CW = $clog2(N_MAX) + 1;
  localparam logic [CW-1:0] L_NVS   = CW'(N_NVS - 1);
  localparam logic [CW-1:0] L_PGS   = CW'(N_PGS - 1);
  localparam logic [CW-1:0] L_PROG  = CW'(N_PROG - 1);
  localparam logic [CW-1:0] L_ERASE = CW'(N_ERASE - 1);
  localparam logic [CW-1:0] L_NVH   = CW'(N_NVH - 1);
  localparam logic [CW-1:0] L_RCV   = CW'(N_RCV - 1);
  logic [2:0] state, nxt;
  logic [CW-1:0] load_val;
  logic erase_l, erase_n, accept, expired;
  assign accept = (state == S_IDLE) && cmd_valid;
  assign erase_n = accept ? cmd_erase : erase_l;
  // next state: each timed state advances once the shared counter runs out
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = !accept ? S_IDLE : (addr[ADDR_W-1:COL_W] >= ROW_END) ? S_DONE : S_SETUP;
      S_SETUP: nxt = expired ? S_NVSTR : S_SETUP;
      S_NVSTR: nxt = !expired ? S_NVSTR : erase_l ? S_NVH : S_PROG;
      S_PROG:  nxt = expired ? S_ADH : S_PROG;
      S_ADH:   nxt = S_NVH;
      S_NVH:   nxt = expired ? S_RCV : S_NVH;
      S_RCV:   nxt = expired ? S_DONE : S_RCV;
      default: nxt = S_IDLE;
    endcase
  end
  // dwell time of the state being entered, loaded into the counter on every transition
  always_comb
    load_val = (nxt == S_SETUP) ? L_NVS :
               (nxt == S_NVSTR) ? (erase_l ? L_ERASE : L_PGS) :
               (nxt == S_PROG)  ? L_PROG :
               (nxt == S_NVH)   ? L_NVH :
               (nxt == S_RCV)   ? L_RCV : '0;
  flash_delay_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .rst     (reset),
    .load    (nxt != state),
    .value   (load_val),
    .expired (expired)
  );
  // state, command latches and all outputs registered from the next state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      erase_l <= 1'b0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      inv_valid <= 1'b0;
      inv_addr <= '0;
      flash_xe <= 1'b0;
      flash_ye <= 1'b0;
      flash_prog <= 1'b0;
      flash_erase <= 1'b0;
      flash_nvstr <= 1'b0;
      flash_xadr <= '0;
      flash_yadr <= '0;
      flash_din <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        erase_l <= cmd_erase;
        flash_xadr <= addr[ADDR_W-1:COL_W];
        flash_yadr <= addr[COL_W-1:0];
        flash_din <= data_i;
      end
      cmd_ready <= (nxt == S_IDLE);
      busy <= (nxt != S_IDLE);
      done <= (nxt == S_DONE);
      err <= (nxt == S_DONE) && (state == S_IDLE);
      inv_valid <= (nxt == S_DONE) && (state != S_IDLE);
      if ((nxt == S_DONE) && (state != S_IDLE)) inv_addr <= {flash_xadr, flash_yadr};
      flash_xe <= nxt inside {S_SETUP, S_NVSTR, S_PROG, S_ADH, S_NVH};
      flash_ye <= (nxt == S_PROG);
      flash_prog <= !erase_n && (nxt inside {S_SETUP, S_NVSTR, S_PROG, S_ADH});
      flash_erase <= erase_n && (nxt inside {S_SETUP, S_NVSTR});
      flash_nvstr <= nxt inside {S_NVSTR, S_PROG, S_ADH, S_NVH};
    end
endmodule

// File: tb/tb_user_flash_writer.sv
// tb_user_flash_writer: directed scenario bench for the user flash write controller
module tb_user_flash_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_erase = 1'b0;
  logic [14:0] addr = '0;
  logic [31:0] data_i = '0;
  logic cmd_ready, busy, done, err, inv_valid;
  logic [14:0] inv_addr;
  logic flash_xe, flash_ye, flash_prog, flash_erase, flash_nvstr;
  logic [8:0] flash_xadr;
  logic [5:0] flash_yadr;
  logic [31:0] flash_din;
  int checks = 0;
  int failures = 0;
  int done_cyc, rdy_at, ye_cnt, er_cnt, pr_cnt, any_cnt, order_bad, stab_bad, done_cnt;
  logic err_d, inv_d;
  logic [14:0] inv_a;

  always #5 clk = ~clk;

  user_flash_writer #(
    .CLK_FREQ(1_000_000_000), .T_NVS_NS(4), .T_PGS_NS(6), .T_PROG_NS(8),
    .T_ERASE_NS(20), .T_NVH_NS(4), .T_RCV_NS(5)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_erase(cmd_erase), .addr(addr), .data_i(data_i), .busy(busy), .done(done),
    .err(err), .inv_valid(inv_valid), .inv_addr(inv_addr), .flash_xe(flash_xe),
    .flash_ye(flash_ye), .flash_prog(flash_prog), .flash_erase(flash_erase),
    .flash_nvstr(flash_nvstr), .flash_xadr(flash_xadr), .flash_yadr(flash_yadr),
    .flash_din(flash_din)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issue one command in the current cycle (cycle 0) and watch it until one cycle after done
  task automatic op(input logic e, input logic [14:0] a, input logic [31:0] d, input logic hold);
    cmd_valid = 1'b1; cmd_erase = e; addr = a; data_i = d;
    done_cyc = -1; rdy_at = -1; ye_cnt = 0; er_cnt = 0; pr_cnt = 0; any_cnt = 0;
    order_bad = 0; stab_bad = 0; done_cnt = 0; err_d = 1'bx; inv_d = 1'bx; inv_a = 'x;
    for (int c = 1; c <= 200; c++) begin
      tick;
      if (!hold) cmd_valid = 1'b0;
      else begin addr = 15'h0123; cmd_erase = 1'b0; data_i = 32'h0BAD_F00D; end
      if (cmd_ready && rdy_at < 0) rdy_at = c;
      if (flash_ye) ye_cnt++;
      if (flash_erase) er_cnt++;
      if (flash_prog) pr_cnt++;
      if (flash_xe || flash_ye || flash_prog || flash_erase || flash_nvstr) any_cnt++;
      if ((flash_nvstr && !flash_xe) || (flash_ye && !flash_nvstr) || (flash_prog && flash_erase)) order_bad++;
      if (flash_xe && (flash_xadr !== a[14:6] || flash_yadr !== a[5:0])) stab_bad++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; err_d = err; inv_d = inv_valid; inv_a = inv_addr; end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_handshake: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
    end
    checks++;
    if ({done, err, inv_valid, flash_xe, flash_ye, flash_prog, flash_erase, flash_nvstr} !== 8'h00) begin
      failures++; $display("FAIL reset_strobes: got %b, want 00000000",
        {done, err, inv_valid, flash_xe, flash_ye, flash_prog, flash_erase, flash_nvstr});
    end
    checks++;
    if ({flash_xadr, flash_yadr, flash_din, inv_addr} !== '0) begin
      failures++; $display("FAIL reset_regs: xadr=%h yadr=%h din=%h inv_addr=%h, want 0",
        flash_xadr, flash_yadr, flash_din, inv_addr);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_program;
    op(1'b0, 15'h0041, 32'hDEADBEEF, 1'b0);
    checks++;
    if (done_cyc !== 29) begin failures++; $display("FAIL prog_latency: done at %0d, want 29", done_cyc); end
    checks++;
    if (err_d !== 1'b0 || inv_d !== 1'b1 || inv_a !== 15'h0041) begin
      failures++; $display("FAIL prog_done: err=%b inv_valid=%b inv_addr=%h, want 0 1 0041", err_d, inv_d, inv_a);
    end
    checks++;
    if (ye_cnt !== 8) begin failures++; $display("FAIL prog_ye_width: %0d cycles, want 8", ye_cnt); end
    checks++;
    if (pr_cnt !== 19 || er_cnt !== 0) begin
      failures++; $display("FAIL prog_strobes: prog=%0d erase=%0d cycles, want 19 0", pr_cnt, er_cnt);
    end
    checks++;
    if (flash_xadr !== 9'd1 || flash_yadr !== 6'd1 || flash_din !== 32'hDEADBEEF) begin
      failures++; $display("FAIL prog_latch: xadr=%0d yadr=%0d din=%h, want 1 1 deadbeef", flash_xadr, flash_yadr, flash_din);
    end
    checks++;
    if (order_bad !== 0 || stab_bad !== 0 || done_cnt !== 1) begin
      failures++; $display("FAIL prog_order: order_bad=%0d stab_bad=%0d dones=%0d, want 0 0 1", order_bad, stab_bad, done_cnt);
    end
    checks++;
    if (rdy_at !== 30) begin failures++; $display("FAIL prog_ready: ready at %0d, want 30", rdy_at); end
  endtask

  task automatic test_erase;
    op(1'b1, 15'h12C0, 32'h0, 1'b0);
    checks++;
    if (done_cyc !== 34) begin failures++; $display("FAIL erase_latency: done at %0d, want 34", done_cyc); end
    checks++;
    if (er_cnt !== 24) begin failures++; $display("FAIL erase_width: %0d cycles, want 24", er_cnt); end
    checks++;
    if (ye_cnt !== 0 || pr_cnt !== 0) begin
      failures++; $display("FAIL erase_no_prog: ye=%0d prog=%0d cycles, want 0 0", ye_cnt, pr_cnt);
    end
    checks++;
    if (err_d !== 1'b0 || inv_d !== 1'b1 || inv_a !== 15'h12C0 || flash_xadr !== 9'd75) begin
      failures++; $display("FAIL erase_done: err=%b inv=%b inv_addr=%h xadr=%0d, want 0 1 12c0 75", err_d, inv_d, inv_a, flash_xadr);
    end
    checks++;
    if (order_bad !== 0 || stab_bad !== 0) begin
      failures++; $display("FAIL erase_order: order_bad=%0d stab_bad=%0d, want 0 0", order_bad, stab_bad);
    end
  endtask

  task automatic test_bad_row;
    op(1'b0, 15'h4C00, 32'h1234_5678, 1'b0);
    checks++;
    if (done_cyc !== 1) begin failures++; $display("FAIL badrow_latency: done at %0d, want 1", done_cyc); end
    checks++;
    if (err_d !== 1'b1 || inv_d !== 1'b0) begin
      failures++; $display("FAIL badrow_flags: err=%b inv_valid=%b, want 1 0", err_d, inv_d);
    end
    checks++;
    if (any_cnt !== 0) begin failures++; $display("FAIL badrow_strobes: %0d active cycles, want 0", any_cnt); end
    checks++;
    if (rdy_at !== 2) begin failures++; $display("FAIL badrow_ready: ready at %0d, want 2", rdy_at); end
  endtask

  task automatic test_hold;
    int w;
    op(1'b0, 15'h0085, 32'h0000_0001, 1'b1);
    checks++;
    if (done_cyc !== 29 || rdy_at !== 30) begin
      failures++; $display("FAIL hold_first: done=%0d ready=%0d, want 29 30", done_cyc, rdy_at);
    end
    checks++;
    if (stab_bad !== 0) begin failures++; $display("FAIL hold_ignored: %0d unstable cycles, want 0", stab_bad); end
    tick;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || flash_xadr !== 9'd4 || flash_yadr !== 6'h23 || flash_din !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL hold_second: busy=%b ready=%b xadr=%0d yadr=%h din=%h, want 1 0 4 23 0badf00d",
        busy, cmd_ready, flash_xadr, flash_yadr, flash_din);
    end
    w = 0;
    while (!cmd_ready && w < 100) begin tick; w++; end
    checks++;
    if (cmd_ready !== 1'b1 || w !== 29) begin
      failures++; $display("FAIL hold_drain: ready=%b after %0d cycles, want 1 after 29", cmd_ready, w);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    cmd_valid = 1'b1; cmd_erase = 1'b1; addr = 15'h0080; data_i = '0;
    tick;
    cmd_valid = 1'b0;
    repeat (11) tick;
    checks++;
    if ({flash_xe, flash_erase, flash_nvstr} !== 3'b111) begin
      failures++; $display("FAIL midreset_pre: xe/erase/nvstr=%b, want 111", {flash_xe, flash_erase, flash_nvstr});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({flash_xe, flash_ye, flash_prog, flash_erase, flash_nvstr} !== 5'b0) begin
      failures++; $display("FAIL midreset_strobes: %b, want 00000", {flash_xe, flash_ye, flash_prog, flash_erase, flash_nvstr});
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_busy: busy=%b ready=%b, want 0 1", busy, cmd_ready);
    end
    tick;
    reset = 1'b0;
    n = 0;
    repeat (40) begin tick; if (done || flash_xe) n++; end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL midreset_quiet: %0d cycles with done/xe, want 0", n); end
  endtask

  task automatic test_back_to_back;
    int bad, lat_bad;
    bad = 0; lat_bad = 0;
    op(1'b1, 15'h0100, 32'h0, 1'b0);
    bad += order_bad + stab_bad; if (done_cyc != 34 || rdy_at != 35) lat_bad++;
    op(1'b0, 15'h0105, 32'hA5A5_5A5A, 1'b0);
    bad += order_bad + stab_bad; if (done_cyc != 29 || ye_cnt != 8) lat_bad++;
    op(1'b0, 15'h12FF, 32'hFFFF_0000, 1'b0);
    bad += order_bad + stab_bad; if (done_cyc != 29 || inv_a != 15'h12FF) lat_bad++;
    op(1'b1, 15'h4BC0, 32'h0, 1'b0);
    bad += order_bad + stab_bad; if (done_cyc != 34 || err_d != 1'b0 || er_cnt != 24) lat_bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL b2b_ordering: %0d violations, want 0", bad); end
    checks++;
    if (lat_bad !== 0) begin failures++; $display("FAIL b2b_latency: %0d ops off, want 0", lat_bad); end
  endtask

  initial begin
    test_reset;
    test_program;
    test_erase;
    test_bad_row;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
